modport_slave: RTL and testbench

AXI4-Lite slave register file that terminates the `SLAVE` modport of `axi4l_if`. It exposes `NUM_REGS` read/write registers of `DATA_WIDTH` bits to a single AXI4-Lite master. Each read and write uses a fixed-latency, pulse-style handshake. It is the register-access endpoint for control/status blocks and the reference slave for the master-side `read` task.

---
 rtl/axi4l_pkg.sv | 25 ++
 rtl/axi4l_regfile.sv | 37 +++
 rtl/modport_slave.sv | 158 +++++++++++++++
 tb/tb_modport_slave.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4l_pkg.sv
// Shared AXI4-Lite types: response codes and the slave handshake state encodings.
// Handshake rule on every channel: a transfer happens on the rising aclk edge where
// valid and ready are both high; valid, once raised, holds its payload until that edge.
package axi4l_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axi4l_resp_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'b00,
        W_ACC  = 2'b01,
        W_RESP = 2'b10
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'b00,
        R_ACC  = 2'b01,
        R_DATA = 2'b10
    } r_state_t;

endpackage

// File: rtl/axi4l_regfile.sv
// NUM_REGS x DATA_WIDTH register storage: byte-strobed synchronous write,
// combinational read, synchronous clear while aresetn is low.
module axi4l_regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16,
    parameter int IDX_W      = $clog2(NUM_REGS)
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    we,
    input  logic [IDX_W-1:0]        waddr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic [IDX_W-1:0]        raddr,
    output logic [DATA_WIDTH-1:0]   rdata
);

    logic [DATA_WIDTH-1:0] mem [NUM_REGS];

    // Reset takes priority so a write landing on the reset edge is dropped.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            for (int b = 0; b < DATA_WIDTH/8; b++) begin
                if (wstrb[b]) begin
                    mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/modport_slave.sv
// AXI4-Lite slave register file: independent write and read handshake FSMs with
// fixed-latency single-cycle ready pulses, address decode and DECERR for out-of-range.
module modport_slave
    import axi4l_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [2:0]              awprot,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wvalid,
    output logic                    wready,
    output axi4l_resp_t             bresp,
    output logic                    bvalid,
    input  logic                    bready,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [2:0]              arprot,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output axi4l_resp_t             rresp,
    output logic                    rvalid,
    input  logic                    rready,
    output w_state_t                dbg_w_state,
    output r_state_t                dbg_r_state
);

    localparam int BYTE_LSB = $clog2(DATA_WIDTH/8);
    localparam int IDX_W    = $clog2(NUM_REGS);
    localparam int TAG_LSB  = BYTE_LSB + IDX_W;

    w_state_t              w_state;
    r_state_t              r_state;
    logic [IDX_W-1:0]      aw_idx;
    logic [IDX_W-1:0]      ar_idx;
    logic                  aw_ok;
    logic                  ar_ok;
    logic                  rf_we;
    logic [DATA_WIDTH-1:0] rf_rdata;
    logic                  unused_prot;

    // Any bit set above the register index field selects a non-existent register.
    function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] addr);
        return (addr >> TAG_LSB) == '0;
    endfunction

    assign aw_idx = awaddr[TAG_LSB-1:BYTE_LSB];
    assign ar_idx = araddr[TAG_LSB-1:BYTE_LSB];
    assign aw_ok  = addr_in_range(awaddr);
    assign ar_ok  = addr_in_range(araddr);
    assign rf_we  = (w_state == W_ACC) && aw_ok;

    assign unused_prot = ^{awprot, arprot};

    assign dbg_w_state = w_state;
    assign dbg_r_state = r_state;

    axi4l_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .IDX_W      (IDX_W)
    ) u_regfile (
        .aclk    (aclk),
        .aresetn (aresetn),
        .we      (rf_we),
        .waddr   (aw_idx),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .raddr   (ar_idx),
        .rdata   (rf_rdata)
    );

    // Write path: both valids must be seen together before the ready pulse.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            w_state <= W_IDLE;
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
            bresp   <= OKAY;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (awvalid && wvalid) begin
                        w_state <= W_ACC;
                        awready <= 1'b1;
                        wready  <= 1'b1;
                    end
                end
                W_ACC: begin
                    w_state <= W_RESP;
                    awready <= 1'b0;
                    wready  <= 1'b0;
                    bvalid  <= 1'b1;
                    bresp   <= aw_ok ? OKAY : DECERR;
                end
                W_RESP: begin
                    if (bready) begin
                        w_state <= W_IDLE;
                        bvalid  <= 1'b0;
                    end
                end
                default: begin
                    w_state <= W_IDLE;
                    awready <= 1'b0;
                    wready  <= 1'b0;
                    bvalid  <= 1'b0;
                end
            endcase
        end
    end

    // Read path: data is captured from the pre-edge register contents at the accept edge.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state <= R_IDLE;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rresp   <= OKAY;
            rdata   <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (arvalid) begin
                        r_state <= R_ACC;
                        arready <= 1'b1;
                    end
                end
                R_ACC: begin
                    r_state <= R_DATA;
                    arready <= 1'b0;
                    rvalid  <= 1'b1;
                    rresp   <= ar_ok ? OKAY : DECERR;
                    rdata   <= ar_ok ? rf_rdata : '0;
                end
                R_DATA: begin
                    if (rready) begin
                        r_state <= R_IDLE;
                        rvalid  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= R_IDLE;
                    arready <= 1'b0;
                    rvalid  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_modport_slave.sv
// Bench for modport_slave: directed cases plus randomized serial and concurrent traffic
// checked against a word-array register model with expected-response queues.
module tb_modport_slave;
    import axi4l_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NR = 16;
    localparam int SW = DW/8;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic [AW-1:0] awaddr = '0;
    logic [2:0]    awprot = '0;
    logic          awvalid = 1'b0;
    logic          awready;
    logic [DW-1:0] wdata = '0;
    logic [SW-1:0] wstrb = '0;
    logic          wvalid = 1'b0;
    logic          wready;
    axi4l_resp_t   bresp;
    logic          bvalid;
    logic          bready = 1'b0;
    logic [AW-1:0] araddr = '0;
    logic [2:0]    arprot = '0;
    logic          arvalid = 1'b0;
    logic          arready;
    logic [DW-1:0] rdata;
    axi4l_resp_t   rresp;
    logic          rvalid;
    logic          rready = 1'b0;
    w_state_t      dbg_w_state;
    r_state_t      dbg_r_state;

    always #5 aclk = ~aclk;

    modport_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .dbg_w_state(dbg_w_state), .dbg_r_state(dbg_r_state)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: unexpected condition at %0t", name, $time);
    endtask

    // Behavioural model: one word per register, byte address space of NR words.
    logic [DW-1:0]   exp_mem [NR];
    logic [DW+1:0]   exp_r_q[$];
    logic [1:0]      exp_b_q[$];

    function automatic bit addr_ok(input logic [AW-1:0] a);
        return a < (NR * SW);
    endfunction

    function automatic int addr_reg(input logic [AW-1:0] a);
        return int'((a / SW) % NR);
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_v, input logic [DW-1:0] new_v,
                                            input logic [SW-1:0] strb);
        logic [DW-1:0] mask = '0;
        for (int b = 0; b < SW; b++) if (strb[b]) mask = mask | (DW'(8'hFF) << (8*b));
        return (old_v & ~mask) | (new_v & mask);
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        logic [AW-1:0] a = AW'($urandom_range(0, NR-1) * SW + $urandom_range(0, SW-1));
        if ($urandom_range(0, 9) == 0) a = a | (AW'(1) << $urandom_range(6, AW-1));
        return a;
    endfunction

    // Compare process: every cycle out of reset, responses must match the queue heads.
    always @(negedge aclk) begin
        if (aresetn) begin
            check("aw_w_ready_pair", wready, awready);
            if (bvalid) begin
                check("awready_with_bvalid", awready, 1'b0);
                if (exp_b_q.size() == 0) fail_now("b_unexpected");
                else begin
                    check("bresp", bresp, exp_b_q[0]);
                    if (bready) void'(exp_b_q.pop_front());
                end
            end
            if (rvalid) begin
                check("arready_with_rvalid", arready, 1'b0);
                if (exp_r_q.size() == 0) fail_now("r_unexpected");
                else begin
                    check("r_resp_data", {rresp, rdata}, exp_r_q[0]);
                    if (rready) void'(exp_r_q.pop_front());
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge aclk); #1;
        aresetn = 1'b0;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
        exp_r_q.delete();
        exp_b_q.delete();
        for (int i = 0; i < NR; i++) exp_mem[i] = '0;
        @(posedge aclk);
        @(negedge aclk);
        check("rst_outputs", {awready, wready, bvalid, bresp, arready, rvalid, rresp, rdata}, '0);
        check("rst_states", {dbg_w_state, dbg_r_state}, {W_IDLE, R_IDLE});
        @(posedge aclk); #1;
        aresetn = 1'b1;
    endtask

    task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                            input logic [SW-1:0] strb, input int bdelay, input int skew,
                            output logic [1:0] got_resp);
        int n;
        got_resp = 2'bxx;
        exp_b_q.push_back(addr_ok(addr) ? 2'b00 : 2'b11);
        @(posedge aclk); #1;
        awaddr = addr; awprot = 3'($urandom); wdata = data; wstrb = strb; awvalid = 1'b1;
        if (skew > 0) begin
            repeat (skew) begin
                @(negedge aclk);
                check("lone_awvalid", {awready, wready}, 2'b00);
            end
            @(posedge aclk); #1;
        end
        wvalid = 1'b1;
        n = 0;
        do begin @(negedge aclk); n++; end while (!awready && n < 20);
        check("aw_latency", n, 2);
        if (!awready) begin awvalid = 1'b0; wvalid = 1'b0; return; end
        @(posedge aclk);
        if (addr_ok(addr)) exp_mem[addr_reg(addr)] = merge(exp_mem[addr_reg(addr)], data, strb);
        #1;
        awvalid = 1'b0; wvalid = 1'b0;
        if (bdelay == 0) bready = 1'b1;
        @(negedge aclk);
        check("bvalid_rise", bvalid, 1'b1);
        check("awready_pulse_end", awready, 1'b0);
        got_resp = bresp;
        if (bdelay > 0) begin
            repeat (bdelay) @(posedge aclk);
            #1 bready = 1'b1;
        end
        @(posedge aclk); #1;
        bready = 1'b0;
        @(negedge aclk);
        check("bvalid_fall", bvalid, 1'b0);
    endtask

    task automatic do_read(input logic [AW-1:0] addr, input int rdelay,
                           output logic [DW-1:0] got_data, output logic [1:0] got_resp);
        int n;
        got_data = 'x; got_resp = 2'bxx;
        exp_r_q.push_back(addr_ok(addr) ? {2'b00, exp_mem[addr_reg(addr)]} : {2'b11, {DW{1'b0}}});
        @(posedge aclk); #1;
        araddr = addr; arprot = 3'($urandom); arvalid = 1'b1;
        n = 0;
        do begin @(negedge aclk); n++; end while (!arready && n < 20);
        check("ar_latency", n, 2);
        if (!arready) begin arvalid = 1'b0; return; end
        @(posedge aclk); #1;
        arvalid = 1'b0;
        if (rdelay == 0) rready = 1'b1;
        @(negedge aclk);
        check("rvalid_rise", rvalid, 1'b1);
        check("arready_pulse_end", arready, 1'b0);
        got_data = rdata; got_resp = rresp;
        if (rdelay > 0) begin
            repeat (rdelay) @(posedge aclk);
            #1 rready = 1'b1;
        end
        @(posedge aclk); #1;
        rready = 1'b0;
        @(negedge aclk);
        check("rvalid_fall", rvalid, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DW-1:0] gd, gd2;
        logic [1:0]    gr, gr2;
        logic [AW-1:0] wa, ra;
        int            wr, rr;

        do_reset();

        do_read(32'h0, 0, gd, gr);
        check("rd0_data", gd, 32'h0);
        check("rd0_resp", gr, 2'b00);

        do_write(32'h8, 32'hDEADBEEF, 4'hF, 0, 0, gr);
        check("wr8_bresp", gr, 2'b00);
        do_read(32'h8, 0, gd, gr);
        check("rd8_full", gd, 32'hDEADBEEF);

        do_write(32'h8, 32'h11223344, 4'b0101, 0, 0, gr);
        do_read(32'h8, 0, gd, gr);
        check("rd8_strobe", gd, 32'hDE22BE44);

        do_write(32'h40, 32'hCAFEF00D, 4'hF, 0, 0, gr);
        check("wr40_bresp", gr, 2'b11);
        do_read(32'h40, 0, gd, gr);
        check("rd40_data", gd, 32'h0);
        check("rd40_resp", gr, 2'b11);
        for (int i = 0; i < NR; i++) do_read(AW'(i*SW), 0, gd, gr);

        do_read(32'h8, 5, gd, gr);
        do_write(32'h4, 32'h0BADF00D, 4'hF, 5, 0, gr);
        do_write(32'h8, 32'h00000000, 4'h0, 0, 0, gr);
        do_read(32'h8, 0, gd, gr);
        check("rd8_zero_strobe", gd, 32'hDE22BE44);
        do_write(32'h10, 32'h77665544, 4'hF, 0, 4, gr);

        do_write(32'hC, 32'hA5A50001, 4'hF, 0, 0, gr);
        fork
            do_write(32'hC, 32'h5A5A0002, 4'hF, 1, 0, gr);
            do_read(32'hC, 1, gd, gr2);
        join
        check("collide_old", gd, 32'hA5A50001);
        do_read(32'hC, 0, gd, gr);
        check("after_collide_new", gd, 32'h5A5A0002);

        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 1) == 1)
                do_write(rand_addr(), DW'($urandom), SW'($urandom), $urandom_range(0, 3),
                         $urandom_range(0, 1), gr);
            else
                do_read(rand_addr(), $urandom_range(0, 3), gd, gr);
        end

        for (int i = 0; i < 30; i++) begin
            wr = $urandom_range(0, NR-1);
            rr = (wr + $urandom_range(1, NR-1)) % NR;
            wa = AW'(wr * SW);
            ra = AW'(rr * SW);
            fork
                do_write(wa, DW'($urandom), SW'($urandom), $urandom_range(0, 3), 0, gr);
                do_read(ra, $urandom_range(0, 3), gd2, gr2);
            join
        end

        // Park both paths in their response states, then reset.
        @(posedge aclk); #1;
        exp_b_q.push_back(2'b00);
        exp_r_q.push_back({2'b00, exp_mem[5]});
        awaddr = 32'h14; wdata = 32'h13579BDF; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 32'h14; arvalid = 1'b1;
        repeat (2) @(posedge aclk);
        #1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        repeat (3) begin
            @(negedge aclk);
            check("parked_valids", {bvalid, rvalid}, 2'b11);
        end
        check("parked_states", {dbg_w_state, dbg_r_state}, {W_RESP, R_DATA});
        do_reset();
        for (int i = 0; i < NR; i++) do_read(AW'(i*SW), 0, gd, gr);
        do_read(32'h14, 0, gd, gr);
        check("rd14_after_reset", gd, 32'h0);

        // Reset lands on the write accept edge: the write must not commit.
        @(posedge aclk); #1;
        awaddr = 32'h18; wdata = 32'hFEEDFACE; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        do_reset();
        do_read(32'h18, 0, gd, gr);
        check("rd18_reset_wins", gd, 32'h0);

        repeat (3) @(posedge aclk);
        if (exp_r_q.size() != 0 || exp_b_q.size() != 0) fail_now("leftover_expected");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
